// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-save accumulator.
//   acc_state_e : controller state encoding (ACCUM / RESOLVE / OUTPUT)
//   COUNT_W     : width of the optional beat counter
//                 (present only when CSA_ACCUMULATOR_COUNT_EN is defined)
package csa_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } acc_state_e;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors built from full_adder cells.
//   W         : row width
//   in_0      : new operand
//   in_1      : stored sum vector
//   in_2      : stored carry vector
//   sum_raw   : per-bit sum outputs
//   carry_raw : per-bit carry outputs, not yet shifted (weight 2^(i+1))
module csa_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  output logic [W-1:0] sum_raw,
  output logic [W-1:0] carry_raw
);

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .in_0  (in_0[i]),
      .in_1  (in_1[i]),
      .in_2  (in_2[i]),
      .sum   (sum_raw[i]),
      .carry (carry_raw[i])
    );
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   in_0, in_1, in_2 : the three input bits
//   sum              : in_0 ^ in_1 ^ in_2
//   carry            : majority(in_0, in_1, in_2)
module full_adder (
  input  logic in_0,
  input  logic in_1,
  input  logic in_2,
  output logic sum,
  output logic carry
);

  assign sum   = in_0 ^ in_1 ^ in_2;
  assign carry = (in_0 & in_1) | (in_0 & in_2) | (in_1 & in_2);

endmodule

// File: rtl/csa_accumulator.sv
// Signed burst accumulator holding its running total in carry-save form.
// Each accepted operand goes through one csa_row; the carry-propagate add
// happens once per burst, in the RESOLVE cycle.
//   clk, reset_n           : clock (rising edge), async active-low reset
//   in_data/valid/last     : operand stream, in_last marks the burst end
//   in_ready               : high while accumulating
//   out_data/valid/ready   : resolved burst sum with valid/ready handshake
//   out_count (optional)   : operands in the burst, saturating at 16'hFFFF;
//                            exists only when CSA_ACCUMULATOR_COUNT_EN is defined
//
// state   | meaning
// ACCUM   | accepting operands, compressing them into sum_vec/carry_vec
// RESOLVE | one cycle: out_data <= sum_vec + carry_vec, vectors cleared
// OUTPUT  | out_valid high, waiting for out_ready
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef CSA_ACCUMULATOR_COUNT_EN
  ,
  output logic [COUNT_W-1:0] out_count
`endif
);

  acc_state_e       state;
  logic [ACC_W-1:0] sum_vec;
  logic [ACC_W-1:0] carry_vec;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_carry;
  logic             unused_carry_msb;

  assign x_ext    = ACC_W'($signed(in_data));
  assign in_ready = (state == ACCUM);

  csa_row #(.W(ACC_W)) u_row (
    .in_0      (x_ext),
    .in_1      (sum_vec),
    .in_2      (carry_vec),
    .sum_raw   (row_sum),
    .carry_raw (row_carry)
  );

  // Top carry has weight 2^ACC_W and falls off the modulo-2^ACC_W total.
  assign unused_carry_msb = row_carry[ACC_W-1];

`ifdef CSA_ACCUMULATOR_COUNT_EN
  logic [COUNT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM:   if (in_valid && beat_cnt != '1) beat_cnt <= beat_cnt + COUNT_W'(1);
        RESOLVE: begin
          out_count <= beat_cnt;
          beat_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      sum_vec   <= '0;
      carry_vec <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            sum_vec   <= row_sum;
            carry_vec <= {row_carry[ACC_W-2:0], 1'b0};
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_data  <= sum_vec + carry_vec;
          sum_vec   <= '0;
          carry_vec <= '0;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic        in_valid16 = 1'b0;
  logic        in_last16 = 1'b0;
  logic        in_ready16;
  logic [15:0] out_data16;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;

`ifdef CSA_ACCUMULATOR_COUNT_EN
  logic [15:0] out_count;
  logic [15:0] out_count16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.DATA_W(16), .ACC_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CSA_ACCUMULATOR_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  csa_accumulator #(.DATA_W(16), .ACC_W(16)) dut16 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid16),
    .in_last   (in_last16),
    .in_ready  (in_ready16),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16)
`ifdef CSA_ACCUMULATOR_COUNT_EN
    ,
    .out_count (out_count16)
`endif
  );

  typedef struct packed {
    logic [3:0]       n;
    logic [3:0][15:0] d;
    logic [31:0]      exp;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] burst_d[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends burst_d[0..n-1] with optional idle gaps (in_last pulsed while idle
  // must be ignored), then checks the resolve/output timing and handshake.
  task automatic do_burst(input int n, input logic [31:0] exp, input int stall, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_last  = 1'b1;
          in_data  = 16'($urandom);
          tick();
        end
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = burst_d[i];
      in_last  = (i == n - 1);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = (stall == 0);
    check("resolve_out_valid", 32'(out_valid), 32'd0);
    check("resolve_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("out_data", out_data, exp);
`ifdef CSA_ACCUMULATOR_COUNT_EN
    check("out_count", 32'(out_count), 32'(n));
`endif
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 16'($urandom);
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", out_data, exp);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("out_valid_fall", 32'(out_valid), 32'd0);
    check("ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  task automatic set_vec(input int idx, input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] e, input logic [31:0] exp);
    vecs[idx].n    = 4'(n);
    vecs[idx].d[0] = a;
    vecs[idx].d[1] = b;
    vecs[idx].d[2] = c;
    vecs[idx].d[3] = e;
    vecs[idx].exp  = exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp;
    int          n;

    set_vec(0, 3, 16'd5,    16'hFFFE, 16'd7,    16'd0,    32'd10);
    set_vec(1, 1, 16'h8000, 16'd0,    16'd0,    16'd0,    32'hFFFF8000);
    set_vec(2, 4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h0001FFFC);
    set_vec(3, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0,    32'hFFFFFFFD);
    set_vec(4, 2, 16'h8000, 16'h8000, 16'd0,    16'd0,    32'hFFFF0000);
    set_vec(5, 2, 16'd1,    16'd1,    16'd0,    16'd0,    32'd2);

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    #21;
    reset_n = 1'b1;
    tick();

    // Table-driven bursts: no gaps, one stalled case.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) burst_d[i] = vecs[v].d[i];
      do_burst(int'(vecs[v].n), vecs[v].exp, (v == 3) ? 5 : 0, 1'b0);
    end

    // ACC_W = 16 wrap: four 16'h7FFF beats.
    for (int i = 0; i < 4; i++) begin
      in_valid16 = 1'b1;
      in_data    = 16'h7FFF;
      in_last16  = (i == 3);
      tick();
    end
    in_valid16 = 1'b0;
    in_last16  = 1'b0;
    check("w16_resolve_valid", 32'(out_valid16), 32'd0);
    tick();
    check("w16_out_valid", 32'(out_valid16), 32'd1);
    check("w16_out_data", 32'(out_data16), 32'h0000FFFC);
    tick();
    check("w16_out_valid_fall", 32'(out_valid16), 32'd0);

    // Reset mid-burst: two of four beats accepted, then reset.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd9;
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midburst_rst_out_valid", 32'(out_valid), 32'd0);
    check("midburst_rst_in_ready", 32'(in_ready), 32'd1);
    #2;
    reset_n = 1'b1;
    tick();
    burst_d[0] = 16'd1;
    burst_d[1] = 16'd1;
    do_burst(2, 32'd2, 0, 1'b0);

    // Reset while OUTPUT is stalled: out_valid must drop without a clock edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd3;
    in_last   = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    tick();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_out_data", out_data, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", out_data, 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();

    // Randomized bursts against a plain arithmetic sum model.
    for (int r = 0; r < 30; r++) begin
      n   = $urandom_range(1, 8);
      exp = '0;
      for (int i = 0; i < n; i++) begin
        burst_d[i] = 16'($urandom);
        exp        = exp + 32'($signed(burst_d[i]));
      end
      do_burst(n, exp, $urandom_range(0, 3), 1'b1);
    end

`ifdef CSA_ACCUMULATOR_COUNT_EN
    // Long burst: count saturates, sum keeps going.
    for (int i = 0; i < 70000; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd1;
      in_last  = (i == 69999);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("long_out_valid", 32'(out_valid), 32'd1);
    check("long_out_data", out_data, 32'd70000);
    check("long_out_count", 32'(out_count), 32'h0000FFFF);
    tick();
    check("long_out_valid_fall", 32'(out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
